// File: rtl/npu_host_master_if.sv
// Command/response stream and NPU single-port bus bundle for npu_host_master.
// master = the host master's view; slave = the sequencer/NPU side.
interface npu_host_master_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [2:0]        cmd_sel;
  logic [DATA_W-1:0] cmd_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic              busy;
  logic              ena;
  logic              wea;
  logic [ADDR_W-1:0] addra;
  logic [DATA_W-1:0] dina;
  logic [DATA_W-1:0] douta;

  modport master (
    input  cmd_valid, cmd_op, cmd_sel, cmd_data, rsp_ready, douta,
    output cmd_ready, rsp_valid, rsp_data, rsp_err, busy, ena, wea, addra, dina
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_sel, cmd_data, rsp_ready, douta,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err, busy, ena, wea, addra, dina
  );
endinterface

// File: rtl/npu_host_master.sv
// Host-side bus master: turns WRITE/READ/POLL/NOP commands into single-port NPU accesses
// with registered bus outputs, 1-cycle read latency and an idle gap after control writes.
module npu_host_master #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned SEL_LSB  = 12,
  parameter logic [2:0]  CTRL_SEL = 3'd4,
  parameter int unsigned POLL_MAX = 1024
) (
  input logic               clk,
  input logic               rst_ni,
  npu_host_master_if.master bus
);

  localparam int unsigned CntW = $clog2(POLL_MAX + 1);

  localparam logic [1:0] OpWrite = 2'b00;
  localparam logic [1:0] OpRead  = 2'b01;
  localparam logic [1:0] OpPoll  = 2'b10;

  typedef enum logic [3:0] {
    StIdle, StWrite, StGap, StRdReq, StRdCap, StPollReq, StPollCap, StNop, StRsp
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        sel_q, sel_d;
  logic [DATA_W-1:0] mask_q, mask_d;
  logic [CntW-1:0]   poll_cnt_q, poll_cnt_d;
  logic [7:0]        nop_cnt_q, nop_cnt_d;
  logic              ena_q, ena_d;
  logic              wea_q, wea_d;
  logic [ADDR_W-1:0] addra_q, addra_d;
  logic [DATA_W-1:0] dina_q, dina_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              cmd_accept;

  function automatic logic [ADDR_W-1:0] sel_addr(input logic [2:0] sel);
    logic [ADDR_W-1:0] a;
    a = '0;
    a[SEL_LSB +: 3] = sel;
    return a;
  endfunction

  assign cmd_accept = bus.cmd_valid && (state_q == StIdle) && !rsp_valid_q;

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    mask_d      = mask_q;
    poll_cnt_d  = poll_cnt_q;
    nop_cnt_d   = nop_cnt_q;
    ena_d       = 1'b0;
    wea_d       = 1'b0;
    addra_d     = addra_q;
    dina_d      = dina_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      StIdle: begin
        if (cmd_accept) begin
          sel_d  = bus.cmd_sel;
          mask_d = bus.cmd_data;
          case (bus.cmd_op)
            OpWrite: begin
              state_d = StWrite;
              ena_d   = 1'b1;
              wea_d   = 1'b1;
              addra_d = sel_addr(bus.cmd_sel);
              dina_d  = bus.cmd_data;
            end
            OpRead: begin
              state_d = StRdReq;
              ena_d   = 1'b1;
              addra_d = sel_addr(bus.cmd_sel);
            end
            OpPoll: begin
              state_d    = StPollReq;
              ena_d      = 1'b1;
              addra_d    = sel_addr(bus.cmd_sel);
              poll_cnt_d = '0;
            end
            default: begin
              nop_cnt_d = bus.cmd_data[7:0];
              if (bus.cmd_data[7:0] != 8'd0) state_d = StNop;
            end
          endcase
        end
      end
      // Control writes need one idle cycle so the NPU can self-clear its pulse bits.
      StWrite:   state_d = (sel_q == CTRL_SEL) ? StGap : StIdle;
      StGap:     state_d = StIdle;
      StRdReq:   state_d = StRdCap;
      StRdCap: begin
        rsp_data_d  = bus.douta;
        rsp_err_d   = 1'b0;
        rsp_valid_d = 1'b1;
        state_d     = StRsp;
      end
      StPollReq: state_d = StPollCap;
      StPollCap: begin
        if ((bus.douta & mask_q) != '0) begin
          rsp_data_d  = bus.douta;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = StRsp;
        end else begin
          poll_cnt_d = poll_cnt_q + 1'b1;
          if (poll_cnt_d == CntW'(POLL_MAX)) begin
            rsp_data_d  = bus.douta;
            rsp_err_d   = 1'b1;
            rsp_valid_d = 1'b1;
            state_d     = StRsp;
          end else begin
            ena_d   = 1'b1;
            state_d = StPollReq;
          end
        end
      end
      StNop: begin
        nop_cnt_d = nop_cnt_q - 8'd1;
        if (nop_cnt_q <= 8'd1) state_d = StIdle;
      end
      StRsp: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      sel_q       <= '0;
      mask_q      <= '0;
      poll_cnt_q  <= '0;
      nop_cnt_q   <= '0;
      ena_q       <= 1'b0;
      wea_q       <= 1'b0;
      addra_q     <= '0;
      dina_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      mask_q      <= mask_d;
      poll_cnt_q  <= poll_cnt_d;
      nop_cnt_q   <= nop_cnt_d;
      ena_q       <= ena_d;
      wea_q       <= wea_d;
      addra_q     <= addra_d;
      dina_q      <= dina_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign bus.cmd_ready = (state_q == StIdle) && !rsp_valid_q;
  assign bus.busy      = (state_q != StIdle) || rsp_valid_q;
  assign bus.ena       = ena_q;
  assign bus.wea       = wea_q;
  assign bus.addra     = addra_q;
  assign bus.dina      = dina_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_npu_host_master.sv
// Bench for npu_host_master: directed cases plus random commands against a
// command-level model of latency, bus traffic and NPU register contents.
module tb_npu_host_master;
  localparam int unsigned PollMax = 4;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  npu_host_master_if #(.ADDR_W(16), .DATA_W(32)) bus ();

  npu_host_master #(
    .ADDR_W(16), .DATA_W(32), .SEL_LSB(12), .CTRL_SEL(3'd4), .POLL_MAX(PollMax)
  ) dut (
    .clk(clk),
    .rst_ni(rst_ni),
    .bus(bus)
  );

  int total = 0;
  int bad = 0;

  // NPU stand-in: register file, read data only valid the cycle after a read access.
  bit   [31:0] mem [8];
  int          rd_total = 0;
  int          wr_total = 0;
  int          bad_we = 0;
  logic [15:0] last_rd_addr;
  logic [15:0] last_wr_addr;
  logic [31:0] last_wr_data;
  bit          ramp_on = 1'b0;
  int          ramp_at = 0;
  logic [31:0] ramp_val = '0;

  always @(posedge clk) begin
    if (bus.ena && bus.wea) begin
      mem[bus.addra[14:12]] <= bus.dina;
      wr_total <= wr_total + 1;
      last_wr_addr <= bus.addra;
      last_wr_data <= bus.dina;
    end
    if (bus.ena && !bus.wea) begin
      rd_total <= rd_total + 1;
      last_rd_addr <= bus.addra;
      bus.douta <= (ramp_on && (rd_total + 1 >= ramp_at)) ? ramp_val : mem[bus.addra[14:12]];
    end else begin
      bus.douta <= $urandom;
    end
    if (bus.wea && !bus.ena) bad_we <= bad_we + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] exp_mem [8];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [2:0] sel, input logic [31:0] data);
    int w = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op = op;
    bus.cmd_sel = sel;
    bus.cmd_data = data;
    while (!bus.cmd_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    chk("accept", (w < 40), 1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_op = 2'($urandom);
    bus.cmd_sel = 3'($urandom);
    bus.cmd_data = $urandom;
  endtask

  task automatic take_rsp(input int hold, input logic [31:0] data, input logic err);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("rsp_hold_valid", bus.rsp_valid, 1);
      chk("rsp_hold_data", bus.rsp_data, data);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("rsp_drop", bus.rsp_valid, 0);
    chk("rsp_ready_again", bus.cmd_ready, 1);
  endtask

  task automatic do_write(input logic [2:0] sel, input logic [31:0] data);
    int wr0 = wr_total;
    int lat = 1;
    send(2'b00, sel, data);
    chk("wr_ena", {bus.ena, bus.wea}, 2'b11);
    while (!bus.cmd_ready && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("wr_lat", lat, (sel == 3'd4) ? 3 : 2);
    chk("wr_cnt", wr_total - wr0, 1);
    chk("wr_addr", last_wr_addr, {1'b0, sel, 12'h000});
    chk("wr_data", last_wr_data, data);
    exp_mem[sel] = data;
  endtask

  task automatic do_read(input logic [2:0] sel, input int hold, input bit poke);
    int rd0 = rd_total;
    int wr0 = wr_total;
    int lat = 1;
    send(2'b01, sel, $urandom);
    while (!bus.rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("rd_lat", lat, 3);
    chk("rd_data", bus.rsp_data, exp_mem[sel]);
    chk("rd_err", bus.rsp_err, 0);
    chk("rd_cnt", rd_total - rd0, 1);
    chk("rd_addr", last_rd_addr, {1'b0, sel, 12'h000});
    if (poke) begin
      // Command offered while a response is pending must be left untouched.
      bus.cmd_valid = 1'b1;
      bus.cmd_op = 2'b00;
      chk("busy_ready", bus.cmd_ready, 0);
    end
    take_rsp(hold, exp_mem[sel], 1'b0);
    bus.cmd_valid = 1'b0;
    chk("rd_no_write", wr_total - wr0, 0);
  endtask

  task automatic do_poll(input logic [2:0] sel, input logic [31:0] mask, input int r_at,
                         input logic [31:0] r_val, input int hold);
    int rd0 = rd_total;
    int lat = 1;
    int n_exp = PollMax;
    logic err_exp = 1'b1;
    logic [31:0] v = '0;
    logic [31:0] v_exp = '0;
    for (int r = 1; r <= PollMax; r++) begin
      v = (r_at != 0 && r >= r_at) ? r_val : exp_mem[sel];
      v_exp = v;
      if ((v & mask) != 0) begin
        n_exp = r;
        err_exp = 1'b0;
        break;
      end
    end
    ramp_on = (r_at != 0);
    ramp_at = rd_total + r_at;
    ramp_val = r_val;
    send(2'b10, sel, mask);
    while (!bus.rsp_valid && lat < 4 * PollMax + 10) begin
      @(negedge clk);
      lat++;
    end
    chk("poll_lat", lat, 2 * n_exp + 1);
    chk("poll_cnt", rd_total - rd0, n_exp);
    chk("poll_err", bus.rsp_err, err_exp);
    chk("poll_data", bus.rsp_data, v_exp);
    chk("poll_addr", last_rd_addr, {1'b0, sel, 12'h000});
    take_rsp(hold, v_exp, err_exp);
    ramp_on = 1'b0;
  endtask

  task automatic do_nop(input logic [31:0] data);
    int rd0 = rd_total;
    int wr0 = wr_total;
    int lat = 1;
    bit seen = 1'b0;
    send(2'b11, 3'($urandom), data);
    while (!bus.cmd_ready && lat < 300) begin
      if (bus.ena || bus.rsp_valid) seen = 1'b1;
      @(negedge clk);
      lat++;
    end
    chk("nop_lat", lat, (data[7:0] == 8'd0) ? 1 : int'(data[7:0]) + 1);
    chk("nop_quiet", {seen, bus.rsp_valid}, 2'b00);
    chk("nop_bus", (rd_total - rd0) + (wr_total - wr0), 0);
  endtask

  initial begin
    int rd0;
    logic [1:0]  op;
    logic [2:0]  sel;
    logic [31:0] mask;
    for (int i = 0; i < 8; i++) exp_mem[i] = '0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = 2'b00;
    bus.cmd_sel = 3'd0;
    bus.cmd_data = '0;
    bus.rsp_ready = 1'b0;
    rst_ni = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_bus", {bus.ena, bus.wea, bus.rsp_valid, bus.busy}, 4'b0000);
    rst_ni = 1'b1;
    @(negedge clk);
    chk("rst_ready", bus.cmd_ready, 1);
    chk("rst_addr_dina", {bus.addra, bus.dina}, 48'h0);
    chk("rst_rsp", {bus.rsp_err, bus.rsp_data}, 33'h0);

    do_write(3'd1, 32'h0003_0201);
    do_write(3'd4, 32'h0000_0001);
    do_write(3'd6, 32'hDEAD_BEEF);
    do_read(3'd6, 5, 1'b1);
    do_write(3'd7, 32'h0000_0010);
    do_poll(3'd7, 32'h1, 3, 32'h0000_0011, 0);
    do_write(3'd5, 32'h0);
    do_poll(3'd5, 32'h1, 0, 32'h0, 1);
    do_poll(3'd6, 32'h0, 0, 32'h0, 0);

    // Reset in the middle of a poll that would otherwise time out.
    ramp_on = 1'b0;
    send(2'b10, 3'd2, 32'h0);
    repeat (2) @(negedge clk);
    rst_ni = 1'b0;
    @(negedge clk);
    chk("midrst_bus", {bus.ena, bus.rsp_valid}, 2'b00);
    rst_ni = 1'b1;
    @(negedge clk);
    chk("midrst_ready", {bus.cmd_ready, bus.busy}, 2'b10);
    chk("midrst_regs", {bus.addra, bus.dina, bus.rsp_err, bus.rsp_data}, 81'h0);
    rd0 = rd_total;
    repeat (12) begin
      @(negedge clk);
      if (bus.rsp_valid || bus.ena) chk("midrst_quiet", {bus.rsp_valid, bus.ena}, 2'b00);
    end
    chk("midrst_no_reads", rd_total - rd0, 0);

    do_nop(32'h0000_0003);
    do_nop(32'hFFFF_FF00);

    for (int it = 0; it < 60; it++) begin
      op = 2'($urandom);
      sel = 3'($urandom);
      case (op)
        2'b00: do_write(sel, $urandom);
        2'b01: do_read(sel, $urandom_range(0, 3), 1'b0);
        2'b10: begin
          case ($urandom_range(0, 3))
            0: mask = '0;
            1: mask = 32'h1 << $urandom_range(0, 31);
            default: mask = $urandom;
          endcase
          do_poll(sel, mask, $urandom_range(0, 5), $urandom, $urandom_range(0, 2));
        end
        default: do_nop({$urandom, 8'(0)} | 32'($urandom_range(0, 6)));
      endcase
    end

    chk("we_without_ena", bad_we, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
